reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-write scoreboard for the 5-stage pipeline. Tracks in-flight writes to the 32 GPRs, interlocks the decode stage when a source operand or the destination counter is not yet safe, and releases entries as instructions retire in writeback. Sits between decode (issue side) and writeback (retire side), alongside the GPR file.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired and never tracked
- CNT_W, 2, width of each per-register outstanding-write counter; CNT_MAX = 2^CNT_W-1

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- ds_valid  in  1  decode stage holds a valid instruction
- ds_rs, ds_rt  in  5 each  source register numbers
- ds_rs_used, ds_rt_used  in  1 each  source actually read
- ds_we  in  1  instruction writes a GPR
- ds_dest  in  5  destination register
- es_allowin  in  1  execute stage can accept this cycle
- ds_stall  out  1  decode must hold (hazard)
- ds_issue  out  1  instruction leaves decode this cycle
- ws_valid, ws_we  in  1 each  writeback retiring, with register write
- ws_dest  in  5  retiring destination
- flush  in  1  pipeline flush (exception/eret)
- busy_mask  out  32  bit i = 1 when cnt[i] != 0
- sb_err  out  1  sticky underflow error

## Operation
- State: cnt[1..31], each CNT_W bits; sb_err.
- hazard = (ds_rs_used & ds_rs!=0 & cnt[ds_rs]!=0) | (ds_rt_used & ds_rt!=0 & cnt[ds_rt]!=0) | (ds_we & ds_dest!=0 & cnt[ds_dest]==CNT_MAX).
- ds_stall = ds_valid & hazard; ds_issue = ds_valid & es_allowin & ~hazard.
- inc = ds_issue & ds_we & ds_dest!=0, on one-hot decode of ds_dest.
- dec = ws_valid & ws_we & ws_dest!=0, on one-hot decode of ws_dest.
- Per register: inc only -> +1; dec only -> -1; inc and dec same register same cycle -> unchanged.
- Underflow: dec on cnt==0 -> cnt stays 0, sb_err set; cleared only by reset.
- Overflow impossible by construction (saturated dest stalls).
- flush: all cnt cleared to 0 at next edge; overrides inc and dec that cycle; sb_err unaffected. ds_issue still reported combinationally; the issued write is dropped.
- Writes to register 0 never counted; reads of register 0 never stall.

## Timing
- Reset (async assert, sync release): all cnt=0, busy_mask=0, sb_err=0; ds_stall=0 and ds_issue=ds_valid&es_allowin.
- ds_stall, ds_issue combinational from registered counters and current inputs; no same-cycle bypass.
- Issue at edge N -> dependent instruction sees stall from cycle N+1.
- Retire in cycle N -> stall releases in cycle N+1 (no retire-to-decode forwarding this cycle).
- busy_mask is a direct function of registered counters (updates one cycle after inc/dec/flush).
- ds_stall independent of es_allowin; holding decode due to es_allowin=0 does not change counters.

## Structure
- Shared header sb_defs.vh: NREG, REG_W=5, CNT_W, CNT_MAX.
- Sub-module: decoder_5_32 from the team tool library, instantiated twice (issue dest, retire dest); counters in a generate loop over 1..31.
- Expected size ~150-200 lines.

## Test plan
- Reset mid-operation with cnt[5]=2 -> all busy_mask bits 0 immediately, sb_err=0, ds_stall=0.
- Issue write r5, next cycle decode reads rs=5 -> ds_stall=1 until cycle after ws retires r5, then ds_issue=1; busy_mask[5] 1->0.
- Issue three writes to r7 back-to-back (CNT_W=2) -> cnt[7]=3, fourth write to r7 stalls; a retire of r7 in the same cycle as another r7 issue leaves cnt[7] unchanged.
- Instruction reading r0 and writing r0 while r0 retire also asserted -> no stall, busy_mask=0, sb_err=0.
- Retire r9 with cnt[9]=0 -> sb_err=1 and stays 1 across flush; cnt[9] stays 0.
- Flush with r3,r4,r12 pending plus simultaneous issue to r20 -> busy_mask=0 next cycle, r20 not tracked.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the GPR write scoreboard: register-file geometry and counter sizing.
package reg_scoreboard_pkg;

  localparam int unsigned NregDefault = 32;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned CntWDefault = 2;

  // Largest value a per-register counter can hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard_dec.sv
// 5-to-32 one-hot decoder that omits the hard-wired register 0 from its output range.
module reg_scoreboard_dec
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = NregDefault
) (
  input  logic             en_i,
  input  logic [REG_W-1:0] idx_i,
  output logic [NREG-1:1]  oh_o
);

  always_comb begin
    oh_o = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      oh_o[i] = en_i && (idx_i == REG_W'(i));
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks outstanding GPR writes between decode and writeback and interlocks decode on
// RAW hazards or a saturated destination counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NregDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ds_valid,
  input  logic [REG_W-1:0] ds_rs,
  input  logic [REG_W-1:0] ds_rt,
  input  logic             ds_rs_used,
  input  logic             ds_rt_used,
  input  logic             ds_we,
  input  logic [REG_W-1:0] ds_dest,
  input  logic             es_allowin,
  output logic             ds_stall,
  output logic             ds_issue,
  input  logic             ws_valid,
  input  logic             ws_we,
  input  logic [REG_W-1:0] ws_dest,
  input  logic             flush,
  output logic [NREG-1:0]  busy_mask,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] sat;
  logic [NREG-1:1] inc_oh;
  logic [NREG-1:1] dec_oh;
  logic [NREG-1:1] uflow;
  logic            hazard;
  logic            err_q, err_d;

  // Register 0 is never tracked, so it can never be busy or saturated.
  assign busy[0] = 1'b0;
  assign sat[0]  = 1'b0;

  always_comb begin
    hazard = (ds_rs_used && (ds_rs != '0) && busy[ds_rs])
          || (ds_rt_used && (ds_rt != '0) && busy[ds_rt])
          || (ds_we      && (ds_dest != '0) && sat[ds_dest]);
    ds_stall = ds_valid && hazard;
    ds_issue = ds_valid && es_allowin && !hazard;
  end

  reg_scoreboard_dec #(
    .NREG (NREG)
  ) u_inc_dec (
    .en_i  (ds_issue && ds_we),
    .idx_i (ds_dest),
    .oh_o  (inc_oh)
  );

  reg_scoreboard_dec #(
    .NREG (NREG)
  ) u_ret_dec (
    .en_i  (ws_valid && ws_we),
    .idx_i (ws_dest),
    .oh_o  (dec_oh)
  );

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uflow_c;

    always_comb begin
      cnt_d   = cnt_q;
      uflow_c = 1'b0;
      if (flush) begin
        cnt_d = '0;
      end else if (inc_oh[i] && !dec_oh[i]) begin
        cnt_d = cnt_q + CntOne;
      end else if (dec_oh[i] && !inc_oh[i]) begin
        if (cnt_q == '0) begin
          uflow_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[i]  = (cnt_q != '0);
    assign sat[i]   = (cnt_q == CntMax);
    assign uflow[i] = uflow_c;
  end

  assign err_d = err_q || (|uflow);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign busy_mask = busy;
  assign sb_err    = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: RAW interlock, counter saturation, r0 handling,
// underflow error, flush and asynchronous reset.
module tb_reg_scoreboard;

  logic        clk;
  logic        resetn;
  logic        ds_valid;
  logic [4:0]  ds_rs;
  logic [4:0]  ds_rt;
  logic        ds_rs_used;
  logic        ds_rt_used;
  logic        ds_we;
  logic [4:0]  ds_dest;
  logic        es_allowin;
  logic        ds_stall;
  logic        ds_issue;
  logic        ws_valid;
  logic        ws_we;
  logic [4:0]  ws_dest;
  logic        flush;
  logic [31:0] busy_mask;
  logic        sb_err;

  int n_checks;
  int n_fail;

  reg_scoreboard u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .ds_valid   (ds_valid),
    .ds_rs      (ds_rs),
    .ds_rt      (ds_rt),
    .ds_rs_used (ds_rs_used),
    .ds_rt_used (ds_rt_used),
    .ds_we      (ds_we),
    .ds_dest    (ds_dest),
    .es_allowin (es_allowin),
    .ds_stall   (ds_stall),
    .ds_issue   (ds_issue),
    .ws_valid   (ws_valid),
    .ws_we      (ws_we),
    .ws_dest    (ws_dest),
    .flush      (flush),
    .busy_mask  (busy_mask),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ds_valid   = 1'b0;
    ds_rs      = '0;
    ds_rt      = '0;
    ds_rs_used = 1'b0;
    ds_rt_used = 1'b0;
    ds_we      = 1'b0;
    ds_dest    = '0;
    es_allowin = 1'b1;
    ws_valid   = 1'b0;
    ws_we      = 1'b0;
    ws_dest    = '0;
    flush      = 1'b0;
  endtask

  // Advance one clock; inputs and sampling happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_w(input logic [4:0] dest);
    idle();
    ds_valid = 1'b1;
    ds_we    = 1'b1;
    ds_dest  = dest;
    step();
  endtask

  task automatic retire(input logic [4:0] dest);
    idle();
    ws_valid = 1'b1;
    ws_we    = 1'b1;
    ws_dest  = dest;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    resetn     = 1'b0;
    ds_valid   = 1'b1;
    ds_rs      = 5'd5;
    ds_rs_used = 1'b1;
    #1;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_err", {31'b0, sb_err}, 32'h0);
    check("rst_stall", {31'b0, ds_stall}, 32'h0);
    check("rst_issue", {31'b0, ds_issue}, 32'h1);
    step();
    resetn = 1'b1;

    // RAW on r5 through rs, released the cycle after retire.
    idle();
    ds_valid = 1'b1;
    ds_we    = 1'b1;
    ds_dest  = 5'd5;
    #1;
    check("w5_issue", {31'b0, ds_issue}, 32'h1);
    step();
    check("w5_busy", busy_mask, 32'h20);
    ds_we      = 1'b0;
    ds_rs      = 5'd5;
    ds_rs_used = 1'b1;
    #1;
    check("raw5_stall", {31'b0, ds_stall}, 32'h1);
    check("raw5_noissue", {31'b0, ds_issue}, 32'h0);
    step();
    ws_valid = 1'b1;
    ws_we    = 1'b1;
    ws_dest  = 5'd5;
    #1;
    check("raw5_nofwd", {31'b0, ds_stall}, 32'h1);
    step();
    ws_valid = 1'b0;
    #1;
    check("raw5_release", {31'b0, ds_issue}, 32'h1);
    check("raw5_busy0", busy_mask, 32'h0);

    // rt hazard persists with es_allowin low.
    issue_w(5'd10);
    ds_valid   = 1'b1;
    ds_rt      = 5'd10;
    ds_rt_used = 1'b1;
    es_allowin = 1'b0;
    #1;
    check("rt10_stall", {31'b0, ds_stall}, 32'h1);
    retire(5'd10);
    check("rt10_busy0", busy_mask, 32'h0);

    // Back-pressure holds decode without counting.
    idle();
    ds_valid   = 1'b1;
    ds_we      = 1'b1;
    ds_dest    = 5'd11;
    es_allowin = 1'b0;
    #1;
    check("bp_stall", {31'b0, ds_stall}, 32'h0);
    check("bp_issue", {31'b0, ds_issue}, 32'h0);
    step();
    check("bp_busy", busy_mask, 32'h0);

    // r7 saturation at 3, then simultaneous issue+retire leaves the count at 2.
    issue_w(5'd7);
    issue_w(5'd7);
    issue_w(5'd7);
    check("r7_busy", busy_mask, 32'h80);
    ds_valid = 1'b1;
    ds_we    = 1'b1;
    ds_dest  = 5'd7;
    #1;
    check("r7_sat_stall", {31'b0, ds_stall}, 32'h1);
    retire(5'd7);
    ds_valid = 1'b1;
    ds_we    = 1'b1;
    ds_dest  = 5'd7;
    ws_valid = 1'b1;
    ws_we    = 1'b1;
    ws_dest  = 5'd7;
    #1;
    check("r7_incdec_issue", {31'b0, ds_issue}, 32'h1);
    step();
    ws_valid = 1'b0;
    #1;
    check("r7_cnt2_nostall", {31'b0, ds_stall}, 32'h0);
    step();
    check("r7_cnt3_stall", {31'b0, ds_stall}, 32'h1);
    retire(5'd7);
    retire(5'd7);
    check("r7_cnt1_busy", busy_mask, 32'h80);
    retire(5'd7);
    check("r7_drained", busy_mask, 32'h0);
    check("r7_no_err", {31'b0, sb_err}, 32'h0);

    // r0 is never tracked and never stalls.
    idle();
    ds_valid   = 1'b1;
    ds_rs_used = 1'b1;
    ds_rt_used = 1'b1;
    ds_we      = 1'b1;
    ws_valid   = 1'b1;
    ws_we      = 1'b1;
    #1;
    check("r0_stall", {31'b0, ds_stall}, 32'h0);
    check("r0_issue", {31'b0, ds_issue}, 32'h1);
    step();
    check("r0_busy", busy_mask, 32'h0);
    check("r0_err", {31'b0, sb_err}, 32'h0);

    // Flush drops pending r3/r4/r12 and the concurrently issued r20.
    issue_w(5'd3);
    issue_w(5'd4);
    issue_w(5'd12);
    check("fl_pending", busy_mask, 32'h1018);
    ds_valid = 1'b1;
    ds_we    = 1'b1;
    ds_dest  = 5'd20;
    flush    = 1'b1;
    #1;
    check("fl_issue", {31'b0, ds_issue}, 32'h1);
    step();
    idle();
    check("fl_busy0", busy_mask, 32'h0);
    ds_valid   = 1'b1;
    ds_rs      = 5'd20;
    ds_rs_used = 1'b1;
    #1;
    check("fl_r20_free", {31'b0, ds_stall}, 32'h0);

    // Underflow on r9 is sticky across flush.
    retire(5'd9);
    check("uf_err", {31'b0, sb_err}, 32'h1);
    check("uf_busy", busy_mask, 32'h0);
    idle();
    flush = 1'b1;
    step();
    idle();
    check("uf_err_flush", {31'b0, sb_err}, 32'h1);

    // Asynchronous reset mid-cycle with cnt[5]=2.
    issue_w(5'd5);
    issue_w(5'd5);
    check("mr_busy", busy_mask, 32'h20);
    ds_valid   = 1'b1;
    ds_rs      = 5'd5;
    ds_rs_used = 1'b1;
    #1;
    check("mr_stall", {31'b0, ds_stall}, 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    check("mr_busy0", busy_mask, 32'h0);
    check("mr_err0", {31'b0, sb_err}, 32'h0);
    check("mr_stall0", {31'b0, ds_stall}, 32'h0);
    check("mr_issue", {31'b0, ds_issue}, 32'h1);
    step();
    resetn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
